// File: rtl/i2c_ccd_reg_slave.sv
// I2C target for CCD config writes {dev, sub-addr, data_hi, data_lo}: ACKs DEV_ADDR, one oREG_WR per 16-bit word.
// Optional register read-back path is compiled in when `I2C_SLAVE_READ_EN is defined.
module i2c_ccd_reg_slave #(
  parameter logic [6:0] DEV_ADDR   = 7'h5D,
  parameter int         FILTER_LEN = 3
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSCL,
  input  logic        iSDA,
  output logic        oSDA_OE,
  output logic        oBUSY,
  output logic        oREG_WR,
  output logic [7:0]  oREG_ADDR,
  output logic [15:0] oREG_WDATA,
  output logic        oREG_RD,
  input  logic [15:0] iREG_RDATA
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_ACK_DEV, S_REG, S_ACK_REG, S_DHI, S_ACK_DHI,
    S_DLO, S_ACK_DLO, S_IGNORE, S_RHI, S_RACK_HI, S_RLO, S_RACK_LO
  } state_t;

  // bit 0 carries SCL, bit 1 carries SDA
  logic [1:0]    sync1, sync2, filt, filt_q;
  logic [CW-1:0] flt_cnt [2];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      sync1  <= {iSDA, iSCL};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i]    <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic sda, scl_hi, scl_rise, scl_fall, start, stop;
  assign sda      = filt[1];
  assign scl_hi   = filt[0] & filt_q[0];
  assign scl_rise = filt[0] & ~filt_q[0];
  assign scl_fall = ~filt[0] & filt_q[0];
  assign start    = scl_hi & ~filt[1] & filt_q[1];
  assign stop     = scl_hi & filt[1] & ~filt_q[1];

  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_n;
  logic [7:0]  shreg, shreg_n, dhi, dhi_n, addr_n;
  logic [15:0] wdata_n;
  logic        oe_n, busy_n, wr_n, byte_end, shift_state;

`ifdef I2C_SLAVE_READ_EN
  logic [15:0] tx, tx_n;
  logic        mack, mack_n, rd_n;
`else
  logic unused_rdata;
  assign unused_rdata = ^iREG_RDATA;
  assign oREG_RD      = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    bit_n    = bit_cnt;
    shreg_n  = shreg;
    dhi_n    = dhi;
    oe_n     = oSDA_OE;
    busy_n   = oBUSY;
    wr_n     = 1'b0;
    addr_n   = oREG_ADDR;
    wdata_n  = oREG_WDATA;
    byte_end = scl_fall && (bit_cnt == 4'd8);
    shift_state = (state == S_DEV) || (state == S_REG) || (state == S_DHI) ||
                  (state == S_DLO) || (state == S_RHI) || (state == S_RLO);
`ifdef I2C_SLAVE_READ_EN
    tx_n   = tx;
    mack_n = mack;
    rd_n   = 1'b0;
    if (oREG_RD) tx_n = iREG_RDATA;
`endif
    if (start) begin
      state_n = S_DEV;
      bit_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b1;
    end else if (stop) begin
      state_n = S_IDLE;
      bit_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      if (scl_rise && (bit_cnt < 4'd8) && shift_state) begin
        shreg_n = {shreg[6:0], sda};
        bit_n   = bit_cnt + 4'd1;
      end
      case (state)
        S_DEV: if (byte_end) begin
          bit_n = '0;
          if (shreg[7:1] == DEV_ADDR && !shreg[0]) begin
            state_n = S_ACK_DEV;
            oe_n    = 1'b1;
`ifdef I2C_SLAVE_READ_EN
          end else if (shreg[7:1] == DEV_ADDR) begin
            state_n = S_ACK_DEV;
            oe_n    = 1'b1;
            rd_n    = 1'b1;
`endif
          end else begin
            state_n = S_IGNORE;
          end
        end
        S_ACK_DEV: if (scl_fall) begin
          oe_n    = 1'b0;
          state_n = S_REG;
`ifdef I2C_SLAVE_READ_EN
          // shreg still holds the DEV byte, so bit 0 is the R/W flag
          if (shreg[0]) begin
            state_n = S_RHI;
            oe_n    = ~tx[15];
          end
`endif
        end
        S_REG: if (byte_end) begin
          addr_n  = shreg;
          bit_n   = '0;
          oe_n    = 1'b1;
          state_n = S_ACK_REG;
        end
        S_ACK_REG: if (scl_fall) begin
          oe_n    = 1'b0;
          state_n = S_DHI;
        end
        S_DHI: if (byte_end) begin
          dhi_n   = shreg;
          bit_n   = '0;
          oe_n    = 1'b1;
          state_n = S_ACK_DHI;
        end
        S_ACK_DHI: if (scl_fall) begin
          oe_n    = 1'b0;
          state_n = S_DLO;
        end
        S_DLO: begin
          if (scl_rise && (bit_cnt == 4'd7)) begin
            wr_n    = 1'b1;
            wdata_n = {dhi, shreg[6:0], sda};
          end
          if (byte_end) begin
            bit_n   = '0;
            oe_n    = 1'b1;
            state_n = S_ACK_DLO;
          end
        end
        S_ACK_DLO: if (scl_fall) begin
          oe_n    = 1'b0;
          addr_n  = oREG_ADDR + 8'd1;
          state_n = S_DHI;
        end
`ifdef I2C_SLAVE_READ_EN
        S_RHI, S_RLO: if (scl_fall) begin
          // tx shifts every fall so tx[15] is always the bit on the wire next
          tx_n = {tx[14:0], 1'b0};
          if (bit_cnt == 4'd8) begin
            oe_n    = 1'b0;
            bit_n   = '0;
            state_n = (state == S_RHI) ? S_RACK_HI : S_RACK_LO;
          end else begin
            oe_n = ~tx[14];
          end
        end
        S_RACK_HI, S_RACK_LO: begin
          if (scl_rise) begin
            mack_n = ~sda;
            if ((state == S_RACK_LO) && !sda) begin
              addr_n = oREG_ADDR + 8'd1;
              rd_n   = 1'b1;
            end
          end
          if (scl_fall) begin
            bit_n = '0;
            if (mack) begin
              state_n = (state == S_RACK_HI) ? S_RLO : S_RHI;
              oe_n    = ~tx[15];
            end else begin
              state_n = S_IGNORE;
              oe_n    = 1'b0;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      dhi        <= '0;
      oSDA_OE    <= 1'b0;
      oBUSY      <= 1'b0;
      oREG_WR    <= 1'b0;
      oREG_ADDR  <= '0;
      oREG_WDATA <= '0;
`ifdef I2C_SLAVE_READ_EN
      tx         <= '0;
      mack       <= 1'b0;
      oREG_RD    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      dhi        <= dhi_n;
      oSDA_OE    <= oe_n;
      oBUSY      <= busy_n;
      oREG_WR    <= wr_n;
      oREG_ADDR  <= addr_n;
      oREG_WDATA <= wdata_n;
`ifdef I2C_SLAVE_READ_EN
      tx         <= tx_n;
      mack       <= mack_n;
      oREG_RD    <= rd_n;
`endif
    end
  end

endmodule
